// File: rtl/fp_align_shifter_if.sv
// Operand/result handshake bundle for the FPU alignment shifter.
// The master side feeds operands and consumes results; the slave side is the shifter.
interface fp_align_shifter_if #(
  parameter int unsigned MANT_W  = 24,
  parameter int unsigned SHIFT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               sign_in;
  logic [MANT_W-1:0]  mant_in;
  logic [SHIFT_W-1:0] shift_in;
  logic               out_valid;
  logic               out_ready;
  logic               sign_out;
  logic [MANT_W-1:0]  mant_out;
  logic               guard_out;
  logic               round_out;
  logic               sticky_out;

  modport master (
    output in_valid, sign_in, mant_in, shift_in, out_ready,
    input  in_ready, out_valid, sign_out, mant_out, guard_out, round_out, sticky_out
  );

  modport slave (
    input  in_valid, sign_in, mant_in, shift_in, out_ready,
    output in_ready, out_valid, sign_out, mant_out, guard_out, round_out, sticky_out
  );
endinterface

// File: rtl/fp_align_shifter.sv
// Sequential right-shift mantissa aligner for FP add/sub: shifts up to STEP bits
// per cycle and collects guard, round and sticky bits for the rounder.
module fp_align_shifter #(
  parameter int unsigned MANT_W  = 24,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned STEP    = 4
) (
  input logic               clk,
  input logic               rst_n,
  fp_align_shifter_if.slave bus
);
  localparam int unsigned EXT_W = MANT_W + 2;
  localparam int unsigned CLAMP = MANT_W + 3;
  localparam int unsigned REM_W = $clog2(CLAMP + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [EXT_W-1:0] r_ext;
  logic             r_sticky;
  logic             r_sign;
  logic [REM_W-1:0] r_rem;

  logic [31:0]      w_shift_wide;
  logic [REM_W-1:0] w_rem_load;
  logic [REM_W-1:0] w_k;
  logic [REM_W-1:0] w_rem_next;
  logic [EXT_W-1:0] w_ext_next;
  logic             w_lost;

  assign w_shift_wide = 32'(bus.shift_in);

  // Any shift of CLAMP or more pushes every mantissa bit past the round position.
  always_comb begin
    w_rem_load = REM_W'(w_shift_wide);
    if (w_shift_wide >= 32'(CLAMP)) begin
      w_rem_load = REM_W'(CLAMP);
    end
  end

  always_comb begin
    w_k = r_rem;
    if (r_rem > REM_W'(STEP)) begin
      w_k = REM_W'(STEP);
    end
  end

  assign w_ext_next = r_ext >> w_k;
  assign w_rem_next = r_rem - w_k;

  // Bits falling off ext[0] this cycle feed the sticky accumulator.
  always_comb begin
    w_lost = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (REM_W'(i) < w_k) begin
        w_lost = w_lost | r_ext[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ext    <= '0;
      r_sticky <= 1'b0;
      r_sign   <= 1'b0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_ext    <= {bus.mant_in, 2'b00};
            r_sticky <= 1'b0;
            r_sign   <= bus.sign_in;
            r_rem    <= w_rem_load;
            r_state  <= (w_rem_load == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_ext    <= w_ext_next;
          r_sticky <= r_sticky | w_lost;
          r_rem    <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.sign_out   = r_sign;
  assign bus.mant_out   = r_ext[EXT_W-1:2];
  assign bus.guard_out  = r_ext[1];
  assign bus.round_out  = r_ext[0];
  assign bus.sticky_out = r_sticky;
endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter (MANT_W=24, STEP=4): expected results are
// computed by a single wide shift at drive time and checked when out_valid appears.
module tb_fp_align_shifter;
  localparam int unsigned MANT_W  = 24;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned STEP    = 4;

  typedef struct {
    logic        sign;
    logic [23:0] mant;
    logic        g;
    logic        r;
    logic        s;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  exp_t q[$];

  fp_align_shifter_if #(.MANT_W(MANT_W), .SHIFT_W(SHIFT_W)) bus ();

  fp_align_shifter #(.MANT_W(MANT_W), .SHIFT_W(SHIFT_W), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic sgn, input logic [23:0] m, input logic [4:0] sh);
    exp_t        e;
    logic [57:0] full;
    int          s;
    s      = (int'(sh) >= 27) ? 27 : int'(sh);
    full   = {m, 2'b00, 32'h0} >> s;
    e.sign = sgn;
    e.mant = full[57:34];
    e.g    = full[33];
    e.r    = full[32];
    e.s    = |full[31:0];
    e.lat  = 1 + (s + 3) / 4;
    return e;
  endfunction

  task automatic scramble_inputs();
    bus.mant_in  = 24'($urandom);
    bus.shift_in = 5'($urandom);
    bus.sign_in  = 1'($urandom);
  endtask

  // Drive one operation, optionally toggling inputs while busy, then hold DONE for 'hold' cycles.
  task automatic do_op(input logic sgn, input logic [23:0] m, input logic [4:0] sh,
                       input int hold, input bit noise);
    exp_t        e;
    int          waitc;
    int          lat;
    logic [23:0] held_mant;
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    q.push_back(model(sgn, m, sh));
    bus.in_valid = 1'b1;
    bus.sign_in  = sgn;
    bus.mant_in  = m;
    bus.shift_in = sh;
    @(posedge clk);
    @(negedge clk);
    if (noise) scramble_inputs();
    else bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (noise) begin
        check_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
        scramble_inputs();
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check_eq("out_valid_seen", 32'(bus.out_valid), 32'd1);
    if (q.size() == 0) begin
      check_eq("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check_eq("latency", 32'(lat), 32'(e.lat));
      check_eq("mant_out", 32'(bus.mant_out), 32'(e.mant));
      check_eq("guard_out", 32'(bus.guard_out), 32'(e.g));
      check_eq("round_out", 32'(bus.round_out), 32'(e.r));
      check_eq("sticky_out", 32'(bus.sticky_out), 32'(e.s));
      check_eq("sign_out", 32'(bus.sign_out), 32'(e.sign));
    end
    held_mant = bus.mant_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("hold_mant_out", 32'(bus.mant_out), 32'(held_mant));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("release_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.mant_in   = '0;
    bus.shift_in  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_mant_out", 32'(bus.mant_out), 32'd0);
    check_eq("rst_grs", 32'({bus.guard_out, bus.round_out, bus.sticky_out}), 32'd0);
    check_eq("rst_sign_out", 32'(bus.sign_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(1'b0, 24'hC00001, 5'd0,  0, 1'b0);
    do_op(1'b1, 24'h800007, 5'd3,  0, 1'b0);
    do_op(1'b0, 24'h800100, 5'd9,  0, 1'b1);
    do_op(1'b1, 24'hFFFFFF, 5'd31, 0, 1'b0);
    do_op(1'b0, 24'h800100, 5'd9,  5, 1'b0);
    do_op(1'b1, 24'h800007, 5'd3,  0, 1'b0);
    do_op(1'b0, 24'h000000, 5'd13, 0, 1'b0);
    do_op(1'b0, 24'h800001, 5'd26, 0, 1'b0);
    do_op(1'b1, 24'hC00000, 5'd27, 0, 1'b0);
    do_op(1'b0, 24'h000001, 5'd28, 1, 1'b0);
    do_op(1'b0, 24'hABCDEF, 5'd4,  0, 1'b1);

    // Abort an operation mid-shift with reset.
    bus.in_valid = 1'b1;
    bus.sign_in  = 1'b1;
    bus.mant_in  = 24'h123457;
    bus.shift_in = 5'd20;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_abort_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_mant_out", 32'(bus.mant_out), 32'd0);
    check_eq("abort_grs", 32'({bus.guard_out, bus.round_out, bus.sticky_out}), 32'd0);
    check_eq("abort_sign_out", 32'(bus.sign_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(1'b1, 24'h800007, 5'd3, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      do_op(1'($urandom), 24'($urandom), 5'($urandom), int'($urandom_range(0, 2)),
            1'($urandom));
    end

    check_eq("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
